// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock that shares one byte-wide UART transmitter.
// A locked owner that leaves REQ_VALID low for LOCK_TIMEOUT cycles loses the grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 12000
) (
    input  logic                   SER_CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    input  logic [8*NUM_REQ-1:0]   REQ_BYTE,
    input  logic [NUM_REQ-1:0]     REQ_LAST,
    output logic [NUM_REQ-1:0]     REQ_READY,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic                   TX_DV,
    output logic [7:0]             TX_BYTE,
    input  logic                   TX_DONE,
    output logic                   BUSY,
    output logic                   LOCK_TO
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_LOCKED    = 2'd3;

    localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [31:0]        TO_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        if (idx == LAST_IDX) begin
            return {IW{1'b0}};
        end else begin
            return idx + IW'(1);
        end
    endfunction

    // Returns {found, index}: first valid requester at or after ptr, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IW-1:0]      ptr);
        logic [IW:0]   pick;
        logic [IW-1:0] idx;
        pick = {(IW+1){1'b0}};
        idx  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick[IW] && valid[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    logic [1:0]         state_r,    state_nx_s;
    logic [NUM_REQ-1:0] grant_r,    grant_nx_s;
    logic [IW-1:0]      owner_r,    owner_nx_s;
    logic [IW-1:0]      ptr_r,      ptr_nx_s;
    logic [31:0]        lock_cnt_r, lock_cnt_nx_s;
    logic [7:0]         tx_byte_r,  tx_byte_nx_s;
    logic               last_r,     last_nx_s;
    logic               tx_dv_r,    tx_dv_nx_s;
    logic [NUM_REQ-1:0] ready_r,    ready_nx_s;
    logic               busy_r,     busy_nx_s;
    logic               lock_to_r,  lock_to_nx_s;

    logic [IW:0]        pick_s;
    logic               pick_vld_s;
    logic [IW-1:0]      pick_idx_s;

    assign pick_s     = rr_pick(REQ_VALID, ptr_r);
    assign pick_vld_s = pick_s[IW];
    assign pick_idx_s = pick_s[IW-1:0];

    // Next-state and next-output decode; all outputs are registered from these values.
    always_comb begin
        state_nx_s    = state_r;
        grant_nx_s    = grant_r;
        owner_nx_s    = owner_r;
        ptr_nx_s      = ptr_r;
        lock_cnt_nx_s = lock_cnt_r;
        tx_byte_nx_s  = tx_byte_r;
        last_nx_s     = last_r;
        tx_dv_nx_s    = 1'b0;
        ready_nx_s    = {NUM_REQ{1'b0}};
        lock_to_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_nx_s   = ST_LOAD;
                    owner_nx_s   = pick_idx_s;
                    grant_nx_s   = ONE_HOT0 << pick_idx_s;
                    ready_nx_s   = ONE_HOT0 << pick_idx_s;
                    tx_dv_nx_s   = 1'b1;
                    tx_byte_nx_s = REQ_BYTE[{pick_idx_s, 3'b000} +: 8];
                    last_nx_s    = REQ_LAST[pick_idx_s];
                end else begin
                    grant_nx_s   = {NUM_REQ{1'b0}};
                end
            end
            ST_LOAD: begin
                state_nx_s = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (TX_DONE) begin
                    if (last_r) begin
                        state_nx_s = ST_IDLE;
                        grant_nx_s = {NUM_REQ{1'b0}};
                        ptr_nx_s   = wrap_inc(owner_r);
                    end else begin
                        state_nx_s    = ST_LOCKED;
                        lock_cnt_nx_s = 32'd0;
                    end
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            ST_LOCKED: begin
                // Other requesters are not scanned here; only the owner can continue.
                if (REQ_VALID[owner_r]) begin
                    state_nx_s   = ST_LOAD;
                    ready_nx_s   = grant_r;
                    tx_dv_nx_s   = 1'b1;
                    tx_byte_nx_s = REQ_BYTE[{owner_r, 3'b000} +: 8];
                    last_nx_s    = REQ_LAST[owner_r];
                end else if (lock_cnt_r == TO_LAST) begin
                    state_nx_s    = ST_IDLE;
                    grant_nx_s    = {NUM_REQ{1'b0}};
                    ptr_nx_s      = wrap_inc(owner_r);
                    lock_to_nx_s  = 1'b1;
                    lock_cnt_nx_s = 32'd0;
                end else begin
                    lock_cnt_nx_s = lock_cnt_r + 32'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                grant_nx_s = {NUM_REQ{1'b0}};
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge SER_CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NUM_REQ{1'b0}};
            owner_r    <= {IW{1'b0}};
            ptr_r      <= {IW{1'b0}};
            lock_cnt_r <= 32'd0;
            tx_byte_r  <= 8'd0;
            last_r     <= 1'b0;
            tx_dv_r    <= 1'b0;
            ready_r    <= {NUM_REQ{1'b0}};
            busy_r     <= 1'b0;
            lock_to_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            grant_r    <= grant_nx_s;
            owner_r    <= owner_nx_s;
            ptr_r      <= ptr_nx_s;
            lock_cnt_r <= lock_cnt_nx_s;
            tx_byte_r  <= tx_byte_nx_s;
            last_r     <= last_nx_s;
            tx_dv_r    <= tx_dv_nx_s;
            ready_r    <= ready_nx_s;
            busy_r     <= busy_nx_s;
            lock_to_r  <= lock_to_nx_s;
        end
    end

    assign REQ_READY = ready_r;
    assign GRANT     = grant_r;
    assign TX_DV     = tx_dv_r;
    assign TX_BYTE   = tx_byte_r;
    assign BUSY      = busy_r;
    assign LOCK_TO   = lock_to_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requesters, a delayed-TX_DONE transmitter
// model, and expected {grant, byte} entries popped on every TX_DV.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int LOCK_TIMEOUT = 8;
    localparam int TX_DLY       = 3;

    logic                 SER_CLK = 1'b0;
    logic                 RST;
    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_BYTE;
    logic [NUM_REQ-1:0]   REQ_LAST;
    logic [NUM_REQ-1:0]   REQ_READY;
    logic [NUM_REQ-1:0]   GRANT;
    logic                 TX_DV;
    logic [7:0]           TX_BYTE;
    logic                 TX_DONE;
    logic                 BUSY;
    logic                 LOCK_TO;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .SER_CLK   (SER_CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_BYTE  (REQ_BYTE),
        .REQ_LAST  (REQ_LAST),
        .REQ_READY (REQ_READY),
        .GRANT     (GRANT),
        .TX_DV     (TX_DV),
        .TX_BYTE   (TX_BYTE),
        .TX_DONE   (TX_DONE),
        .BUSY      (BUSY),
        .LOCK_TO   (LOCK_TO)
    );

    always #5 SER_CLK = ~SER_CLK;

    int          n_vec;
    int          n_err;
    int          cyc;
    int          done_cyc;
    int          n_txdv;
    int          tx_cnt;
    int          ready_cnt [NUM_REQ];
    logic        inflight;
    logic        tx_auto;
    logic        stray_pend;
    logic [8:0]  rq_q [NUM_REQ][$];   // {last, byte}
    logic [11:0] sb_q [$];            // {grant, byte}

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rq_empty();
        logic e;
        e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    // One clock: sample just after the edge, run transmitter model, monitor, requesters.
    task automatic tick();
        logic [11:0] exp_e;
        logic [8:0]  item;
        @(posedge SER_CLK);
        #1;
        cyc++;
        TX_DONE = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                TX_DONE  = 1'b1;
                inflight = 1'b0;
                done_cyc = cyc;
            end
        end else if (stray_pend) begin
            TX_DONE    = 1'b1;
            stray_pend = 1'b0;
            inflight   = 1'b0;
        end
        if (TX_DV) begin
            n_txdv++;
            check_val("no_overlap", 32'(inflight), 32'd0);
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_e = sb_q.pop_front();
                check_val("tx_byte", 32'(TX_BYTE), 32'(exp_e[7:0]));
                check_val("tx_grant", 32'(GRANT), 32'(exp_e[11:8]));
                check_val("tx_ready", 32'(REQ_READY), 32'(exp_e[11:8]));
            end
            inflight = 1'b1;
            if (tx_auto) tx_cnt = TX_DLY;
        end else if (REQ_READY != '0) begin
            check_val("stray_ready", 32'(REQ_READY), 32'd0);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (REQ_READY[i]) begin
                ready_cnt[i]++;
                if (rq_q[i].size() != 0) void'(rq_q[i].pop_front());
            end
            if (rq_q[i].size() != 0) begin
                item               = rq_q[i][0];
                REQ_VALID[i]       = 1'b1;
                REQ_BYTE[8*i +: 8] = item[7:0];
                REQ_LAST[i]        = item[8];
            end else begin
                REQ_VALID[i]       = 1'b0;
                REQ_BYTE[8*i +: 8] = 8'h00;
                REQ_LAST[i]        = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && !(sb_q.size() == 0 && rq_empty() && !BUSY && !inflight)) begin
            tick();
            k++;
        end
        check_val(tag, 32'(BUSY || inflight || sb_q.size() != 0), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_grant"}, 32'(GRANT), 32'd0);
        check_val({tag, "_ready"}, 32'(REQ_READY), 32'd0);
        check_val({tag, "_tx_dv"}, 32'(TX_DV), 32'd0);
        check_val({tag, "_tx_byte"}, 32'(TX_BYTE), 32'd0);
        check_val({tag, "_busy"}, 32'(BUSY), 32'd0);
        check_val({tag, "_lock_to"}, 32'(LOCK_TO), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int k;
        int base;
        int exp_to;
        n_vec = 0; n_err = 0; cyc = 0; done_cyc = 0; n_txdv = 0; tx_cnt = 0;
        inflight = 1'b0; tx_auto = 1'b1; stray_pend = 1'b0;
        RST = 1'b1; REQ_VALID = '0; REQ_BYTE = '0; REQ_LAST = '0; TX_DONE = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;

        tick(); tick(); tick();
        check_outputs_zero("reset");
        RST = 1'b0;

        // Single requester 2, byte 0x41, LAST.
        rq_q[2].push_back({1'b1, 8'h41});
        sb_q.push_back({4'b0100, 8'h41});
        tick();
        tick();
        check_val("t1_tx_dv", 32'(TX_DV), 32'd1);
        check_val("t1_ready", 32'(REQ_READY), 32'h4);
        check_val("t1_tx_byte", 32'(TX_BYTE), 32'h41);
        k = 0;
        while (!TX_DONE && k < 20) begin
            tick();
            check_val("t1_grant_hold", 32'(GRANT), 32'h4);
            check_val("t1_byte_hold", 32'(TX_BYTE), 32'h41);
            k++;
        end
        check_val("t1_done_seen", 32'(TX_DONE), 32'd1);
        tick();
        check_val("t1_grant_clear", 32'(GRANT), 32'd0);
        check_val("t1_busy_clear", 32'(BUSY), 32'd0);
        // Pointer is now 3: requester 3 beats requester 0.
        rq_q[0].push_back({1'b1, 8'hB0});
        rq_q[3].push_back({1'b1, 8'hB3});
        sb_q.push_back({4'b1000, 8'hB3});
        sb_q.push_back({4'b0001, 8'hB0});
        wait_idle("t1_ptr_idle", 60);

        // Contention after reset: requesters 0, 1, 3 rotate.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
        for (int r = 0; r < 3; r++) begin
            rq_q[0].push_back({1'b1, 8'hA0});
            rq_q[1].push_back({1'b1, 8'hA1});
            rq_q[3].push_back({1'b1, 8'hA3});
            sb_q.push_back({4'b0001, 8'hA0});
            sb_q.push_back({4'b0010, 8'hA1});
            sb_q.push_back({4'b1000, 8'hA3});
        end
        wait_idle("t2_idle", 150);
        check_val("t2_rq2_never_ready", 32'(ready_cnt[2]), 32'd0);

        // Packet lock: move pointer to 1, then requester 1 sends a 3-byte packet against 0.
        rq_q[0].push_back({1'b1, 8'h30});
        sb_q.push_back({4'b0001, 8'h30});
        wait_idle("t3_pre_idle", 40);
        rq_q[1].push_back({1'b0, 8'h10});
        rq_q[1].push_back({1'b0, 8'h11});
        rq_q[1].push_back({1'b1, 8'h12});
        rq_q[0].push_back({1'b1, 8'h20});
        sb_q.push_back({4'b0010, 8'h10});
        sb_q.push_back({4'b0010, 8'h11});
        sb_q.push_back({4'b0010, 8'h12});
        sb_q.push_back({4'b0001, 8'h20});
        base = n_txdv;
        k = 0;
        while ((sb_q.size() != 0 || BUSY) && k < 100) begin
            tick();
            k++;
            if (BUSY && (n_txdv - base) < 3) check_val("t3_grant_lock", 32'(GRANT), 32'h2);
        end
        wait_idle("t3_idle", 40);

        // Lock timeout with a stray TX_DONE while locked.
        do_reset();
        rq_q[0].push_back({1'b0, 8'h55});
        rq_q[1].push_back({1'b1, 8'h66});
        sb_q.push_back({4'b0001, 8'h55});
        sb_q.push_back({4'b0010, 8'h66});
        k = 0;
        while (!TX_DONE && k < 20) begin
            tick();
            k++;
        end
        check_val("t4_done_seen", 32'(TX_DONE), 32'd1);
        exp_to = done_cyc + 1 + LOCK_TIMEOUT;
        for (int j = 0; j < LOCK_TIMEOUT + 2; j++) begin
            if (cyc == done_cyc + 3) stray_pend = 1'b1;
            tick();
            check_val("t4_lock_to", 32'(LOCK_TO), 32'(cyc == exp_to));
            if (cyc <= exp_to) begin
                check_val("t4_no_dv", 32'(TX_DV), 32'd0);
            end
            if (cyc < exp_to) begin
                check_val("t4_grant_held", 32'(GRANT), 32'h1);
            end
            if (cyc == exp_to) begin
                check_val("t4_grant_clear", 32'(GRANT), 32'd0);
                check_val("t4_busy_clear", 32'(BUSY), 32'd0);
            end
            if (cyc == exp_to + 1) begin
                check_val("t4_next_dv", 32'(TX_DV), 32'd1);
                check_val("t4_next_grant", 32'(GRANT), 32'h2);
            end
        end
        wait_idle("t4_idle", 40);

        // Stray TX_DONE in IDLE.
        stray_pend = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check_val("t5_idle_dv", 32'(TX_DV), 32'd0);
            check_val("t5_idle_busy", 32'(BUSY), 32'd0);
        end

        // Reset while in WAIT_DONE; the late TX_DONE must be ignored and pointer back to 0.
        tx_auto = 1'b0;
        rq_q[2].push_back({1'b1, 8'h77});
        sb_q.push_back({4'b0100, 8'h77});
        base = n_txdv;
        k = 0;
        while (n_txdv == base && k < 10) begin
            tick();
            k++;
        end
        tick();
        check_val("t6_waiting", 32'(BUSY), 32'd1);
        RST = 1'b1;
        tick();
        check_outputs_zero("t6_rst");
        RST = 1'b0;
        tx_auto = 1'b1;
        stray_pend = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check_val("t6_late_done_dv", 32'(TX_DV), 32'd0);
            check_val("t6_late_done_busy", 32'(BUSY), 32'd0);
        end
        rq_q[1].push_back({1'b1, 8'h91});
        rq_q[3].push_back({1'b1, 8'h93});
        sb_q.push_back({4'b0010, 8'h91});
        sb_q.push_back({4'b1000, 8'h93});
        wait_idle("t6_idle", 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
